// File: rtl/data_sram_responder.sv
// Data-side SRAM responder: byte-writable word RAM plus a small MMIO window
// (LED, switches, free-running timer with sticky compare interrupt, scratch).
module data_sram_responder #(
  parameter int          ADDR_W  = 12,
  parameter logic [15:0] MMIO_HI = 16'hBFAF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [7:0]  sw,
  output logic [15:0] led,
  output logic        timer_int
);
  localparam int          DEPTH       = 1 << ADDR_W;
  localparam logic [13:0] OFF_LED     = 14'd0;
  localparam logic [13:0] OFF_SW      = 14'd1;
  localparam logic [13:0] OFF_TIMER   = 14'd2;
  localparam logic [13:0] OFF_SCRATCH = 14'd3;
  localparam logic [13:0] OFF_CMP     = 14'd4;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_val[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_val[8*i +: 8];
      end
    end
    return res;
  endfunction

  logic [31:0]       mem_r [DEPTH];
  logic [31:0]       rdata_r, timer_r, scratch_r, cmp_r;
  logic [15:0]       led_r;
  logic [7:0]        sw_r;
  logic              timer_int_r;

  logic              is_mmio_s, rd_s, wr_s;
  logic [ADDR_W-1:0] word_idx_s;
  logic [13:0]       reg_off_s;
  logic              wr_ram_s, wr_led_s, wr_timer_s, wr_scratch_s, wr_cmp_s;
  logic [31:0]       rd_mux_s, timer_nxt_s;
  logic [15:0]       led_nxt_s;
  logic              timer_int_nxt_s;
  logic              unused_s;

  assign unused_s = ^data_sram_addr[1:0];

  // Address decode and request classification
  always_comb begin
    is_mmio_s    = (data_sram_addr[31:16] == MMIO_HI);
    reg_off_s    = data_sram_addr[15:2];
    word_idx_s   = data_sram_addr[ADDR_W+1:2];
    rd_s         = data_sram_en && (data_sram_wen == 4'b0000);
    wr_s         = data_sram_en && (data_sram_wen != 4'b0000);
    wr_ram_s     = wr_s && !is_mmio_s;
    wr_led_s     = wr_s && is_mmio_s && (reg_off_s == OFF_LED);
    wr_timer_s   = wr_s && is_mmio_s && (reg_off_s == OFF_TIMER);
    wr_scratch_s = wr_s && is_mmio_s && (reg_off_s == OFF_SCRATCH);
    wr_cmp_s     = wr_s && is_mmio_s && (reg_off_s == OFF_CMP);
  end

  // Read data source selection; timer is returned before this edge's increment
  always_comb begin
    rd_mux_s = 32'h0000_0000;
    if (is_mmio_s) begin
      case (reg_off_s)
        OFF_LED:     rd_mux_s = {16'h0000, led_r};
        OFF_SW:      rd_mux_s = {24'h00_0000, sw_r};
        OFF_TIMER:   rd_mux_s = timer_r;
        OFF_SCRATCH: rd_mux_s = scratch_r;
        OFF_CMP:     rd_mux_s = cmp_r;
        default:     rd_mux_s = 32'h0000_0000;
      endcase
    end else begin
      rd_mux_s = mem_r[word_idx_s];
    end
  end

  // Next-state for LED, timer and the sticky interrupt (compare write beats a match)
  always_comb begin
    if (wr_led_s) begin
      led_nxt_s = {data_sram_wen[1] ? data_sram_wdata[15:8] : led_r[15:8],
                   data_sram_wen[0] ? data_sram_wdata[7:0]  : led_r[7:0]};
    end else begin
      led_nxt_s = led_r;
    end
    if (wr_timer_s) begin
      timer_nxt_s = byte_merge(timer_r, data_sram_wdata, data_sram_wen);
    end else begin
      timer_nxt_s = timer_r + 32'd1;
    end
    if (wr_cmp_s) begin
      timer_int_nxt_s = 1'b0;
    end else if (timer_r == cmp_r) begin
      timer_int_nxt_s = 1'b1;
    end else begin
      timer_int_nxt_s = timer_int_r;
    end
  end

  // Register file, switch sampling and read response
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_r     <= 32'h0000_0000;
      led_r       <= 16'h0000;
      sw_r        <= 8'h00;
      timer_r     <= 32'h0000_0000;
      scratch_r   <= 32'h0000_0000;
      cmp_r       <= 32'hFFFF_FFFF;
      timer_int_r <= 1'b0;
    end else begin
      sw_r        <= sw;
      led_r       <= led_nxt_s;
      timer_r     <= timer_nxt_s;
      timer_int_r <= timer_int_nxt_s;
      if (wr_scratch_s) begin
        scratch_r <= byte_merge(scratch_r, data_sram_wdata, data_sram_wen);
      end
      if (wr_cmp_s) begin
        cmp_r <= byte_merge(cmp_r, data_sram_wdata, data_sram_wen);
      end
      if (rd_s) begin
        rdata_r <= rd_mux_s;
      end
    end
  end

  // RAM array write port; contents survive reset, but requests during reset are dropped
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // array deliberately keeps its contents
    end else if (wr_ram_s) begin
      mem_r[word_idx_s] <= byte_merge(mem_r[word_idx_s], data_sram_wdata, data_sram_wen);
    end
  end

  assign data_sram_rdata = rdata_r;
  assign led             = led_r;
  assign timer_int       = timer_int_r;
endmodule
